serial_subtractor: RTL and testbench



---
 rtl/serial_subtractor_if.sv | 39 +++
 rtl/serial_subtractor.sv | 142 ++++++++++++++
 tb/tb_serial_subtractor.sv | 203 ++++++++++++++++++++
 3 files changed

// File: rtl/serial_subtractor_if.sv
// Handshake bundle for the bit-serial subtractor: operand channel in, result channel out.
// The slave modport is the subtractor itself; the master modport is its producer/consumer.
interface serial_subtractor_if #(
    parameter int WIDTH = 8
);
    logic             in_valid;
    logic             in_ready;
    logic [WIDTH-1:0] a;
    logic [WIDTH-1:0] b;
    logic             out_valid;
    logic             out_ready;
    logic [WIDTH-1:0] diff;
    logic             borrow_out;
    logic             busy;

    modport master (
        output in_valid,
        output a,
        output b,
        output out_ready,
        input  in_ready,
        input  out_valid,
        input  diff,
        input  borrow_out,
        input  busy
    );

    modport slave (
        input  in_valid,
        input  a,
        input  b,
        input  out_ready,
        output in_ready,
        output out_valid,
        output diff,
        output borrow_out,
        output busy
    );
endinterface

// File: rtl/serial_subtractor.sv
// Bit-serial unsigned subtractor: diff = a - b, LSB first, one bit per clock,
// with a single borrow flop and valid/ready handshakes on both sides.
module serial_subtractor #(
    parameter int WIDTH = 8
) (
    input  logic                 clk,
    input  logic                 rst_n,
    serial_subtractor_if.slave   bus
);
    localparam int CNT_W = $clog2(WIDTH) + 1;

    typedef enum logic [1:0] {
        IDLE  = 2'd0,
        SHIFT = 2'd1,
        DONE  = 2'd2
    } state_t;

    state_t           r_state;
    state_t           w_state_next;

    logic [WIDTH-1:0] r_a_sh;
    logic [WIDTH-1:0] r_b_sh;
    logic [WIDTH-2:0] r_res;
    logic             r_borrow;
    logic [CNT_W-1:0] r_cnt;
    logic [WIDTH-1:0] r_diff;
    logic             r_borrow_out;

    logic             w_a0;
    logic             w_b0;
    logic             w_d;
    logic             w_borrow_next;
    logic [WIDTH-1:0] w_a_sh_next;
    logic [WIDTH-1:0] w_b_sh_next;
    logic [WIDTH-1:0] w_res_next;
    logic             w_last;

    logic             w_accept;
    logic             w_shift;
    logic             w_in_ready;
    logic             w_out_valid;
    logic             w_busy;

    // One full-subtractor cell on the current LSBs.
    assign w_a0          = r_a_sh[0];
    assign w_b0          = r_b_sh[0];
    assign w_d           = w_a0 ^ w_b0 ^ r_borrow;
    assign w_borrow_next = (~w_a0 & w_b0) | (~(w_a0 ^ w_b0) & r_borrow);
    assign w_last        = (r_cnt == CNT_W'(WIDTH - 1));

    // Operands shift right with zero fill; the result collects d at the MSB.
    // r_res keeps only the upper WIDTH-1 partial bits; the final bit is
    // merged in when the completed word is loaded into r_diff.
    genvar gi;
    generate
        for (gi = 0; gi < WIDTH - 1; gi++) begin : g_shift
            assign w_a_sh_next[gi] = r_a_sh[gi+1];
            assign w_b_sh_next[gi] = r_b_sh[gi+1];
            assign w_res_next[gi]  = r_res[gi];
        end
    endgenerate
    assign w_a_sh_next[WIDTH-1] = 1'b0;
    assign w_b_sh_next[WIDTH-1] = 1'b0;
    assign w_res_next[WIDTH-1]  = w_d;

    always_comb begin
        w_state_next = r_state;
        w_accept     = 1'b0;
        w_shift      = 1'b0;
        w_in_ready   = 1'b0;
        w_out_valid  = 1'b0;
        w_busy       = 1'b0;
        case (r_state)
            IDLE: begin
                w_in_ready = 1'b1;
                if (bus.in_valid) begin
                    w_accept     = 1'b1;
                    w_state_next = SHIFT;
                end
            end
            SHIFT: begin
                w_busy  = 1'b1;
                w_shift = 1'b1;
                if (w_last) begin
                    w_state_next = DONE;
                end
            end
            DONE: begin
                w_out_valid = 1'b1;
                if (bus.out_ready) begin
                    w_state_next = IDLE;
                end
            end
            default: begin
                w_state_next = IDLE;
            end
        endcase
    end

    always_ff @(posedge clk) begin
        if (!rst_n) begin
            r_state <= IDLE;
        end else begin
            r_state <= w_state_next;
        end
    end

    always_ff @(posedge clk) begin
        if (!rst_n) begin
            r_a_sh       <= '0;
            r_b_sh       <= '0;
            r_res        <= '0;
            r_borrow     <= 1'b0;
            r_cnt        <= '0;
            r_diff       <= '0;
            r_borrow_out <= 1'b0;
        end else if (w_accept) begin
            r_a_sh   <= bus.a;
            r_b_sh   <= bus.b;
            r_res    <= '0;
            r_borrow <= 1'b0;
            r_cnt    <= '0;
        end else if (w_shift) begin
            r_a_sh   <= w_a_sh_next;
            r_b_sh   <= w_b_sh_next;
            r_res    <= w_res_next[WIDTH-1:1];
            r_borrow <= w_borrow_next;
            r_cnt    <= r_cnt + CNT_W'(1);
            if (w_last) begin
                r_diff       <= w_res_next;
                r_borrow_out <= w_borrow_next;
            end
        end
    end

    // Result registers are not cleared on leaving DONE; they hold the last answer.
    assign bus.in_ready   = w_in_ready;
    assign bus.out_valid  = w_out_valid;
    assign bus.busy       = w_busy;
    assign bus.diff       = r_diff;
    assign bus.borrow_out = r_borrow_out;
endmodule

// File: tb/tb_serial_subtractor.sv
// Directed and random checks of serial_subtractor; expected results are queued
// when operands are offered and compared when the result handshake completes.
module tb_serial_subtractor;
    localparam int WIDTH = 8;

    typedef struct {
        logic [WIDTH-1:0] diff;
        logic             borrow;
    } exp_t;

    logic clk;
    logic rst_n;
    exp_t sb_q[$];
    int   n_checks;
    int   n_pass;
    int   n_fail;

    serial_subtractor_if #(.WIDTH(WIDTH)) bus ();

    serial_subtractor #(.WIDTH(WIDTH)) dut (
        .clk   (clk),
        .rst_n (rst_n),
        .bus   (bus)
    );

    initial begin
        clk = 1'b0;
        forever #5 clk = ~clk;
    end

    task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        n_checks++;
        assert (obs === exp) n_pass++;
        else begin
            n_fail++;
            $error("FAIL %s: observed=%0d expected=%0d", tag, obs, exp);
        end
    endtask

    // Offer one operand pair at a negedge; returns at the negedge after acceptance.
    task automatic send(input logic [WIDTH-1:0] a, input logic [WIDTH-1:0] b,
                        input logic [WIDTH-1:0] exp_diff, input logic exp_borrow);
        int guard = 0;
        while (!bus.in_ready && guard < 4 * WIDTH) begin
            @(negedge clk);
            guard++;
        end
        if (!bus.in_ready) begin
            check("send_timeout", 32'(bus.in_ready), 1);
            return;
        end
        bus.a        = a;
        bus.b        = b;
        bus.in_valid = 1'b1;
        sb_q.push_back('{diff: exp_diff, borrow: exp_borrow});
        @(negedge clk);
        bus.in_valid = 1'b0;
        bus.a        = WIDTH'($urandom);
        bus.b        = WIDTH'($urandom);
    endtask

    // Wait for a result, stall it for 'stall' cycles, then compare and accept it.
    task automatic receive(input int stall, input bit rand_rdy);
        int guard = 0;
        exp_t e;
        while (!bus.out_valid && guard < 4 * WIDTH) begin
            if (rand_rdy) bus.out_ready = 1'($urandom_range(0, 1));
            @(negedge clk);
            guard++;
        end
        if (!bus.out_valid) begin
            check("recv_timeout", 32'(bus.out_valid), 1);
            return;
        end
        if (sb_q.size() == 0) begin
            check("sb_nonempty", 32'(sb_q.size()), 1);
            return;
        end
        bus.out_ready = 1'b0;
        repeat (stall) @(negedge clk);
        e = sb_q.pop_front();
        check("diff", 32'(bus.diff), 32'(e.diff));
        check("borrow", 32'(bus.borrow_out), 32'(e.borrow));
        bus.out_ready = 1'b1;
        @(negedge clk);
        bus.out_ready = 1'b0;
    endtask

    logic [WIDTH-1:0] tbl_a [5] = '{8'd3, 8'd0, 8'd255, 8'd255, 8'd0};
    logic [WIDTH-1:0] tbl_b [5] = '{8'd10, 8'd1, 8'd255, 8'd0, 8'd0};
    logic [WIDTH-1:0] tbl_d [5] = '{8'd249, 8'd255, 8'd0, 8'd255, 8'd0};
    logic             tbl_c [5] = '{1'b1, 1'b1, 1'b0, 1'b0, 1'b0};

    initial begin
        logic [WIDTH-1:0] ra;
        logic [WIDTH-1:0] rb;
        logic [WIDTH-1:0] d0;
        logic             c0;
        logic             seen;
        n_checks      = 0;
        n_pass        = 0;
        n_fail        = 0;
        rst_n         = 1'b0;
        bus.in_valid  = 1'b0;
        bus.a         = '0;
        bus.b         = '0;
        bus.out_ready = 1'b0;
        repeat (3) @(negedge clk);
        check("rst_in_ready", 32'(bus.in_ready), 1);
        check("rst_out_valid", 32'(bus.out_valid), 0);
        check("rst_busy", 32'(bus.busy), 0);
        check("rst_diff", 32'(bus.diff), 0);
        check("rst_borrow", 32'(bus.borrow_out), 0);
        rst_n = 1'b1;
        @(negedge clk);

        // Basic 10-3 with out_ready held high: exact latency and handshake timing.
        bus.out_ready = 1'b1;
        bus.a         = 8'd10;
        bus.b         = 8'd3;
        bus.in_valid  = 1'b1;
        @(negedge clk);
        bus.in_valid = 1'b0;
        check("t1_busy", 32'(bus.busy), 1);
        check("t1_in_ready_shift", 32'(bus.in_ready), 0);
        repeat (WIDTH - 1) @(negedge clk);
        check("t1_out_valid_early", 32'(bus.out_valid), 0);
        @(negedge clk);
        check("t1_out_valid", 32'(bus.out_valid), 1);
        check("t1_in_ready_done", 32'(bus.in_ready), 0);
        check("t1_diff", 32'(bus.diff), 7);
        check("t1_borrow", 32'(bus.borrow_out), 0);
        @(negedge clk);
        check("t1_out_valid_drop", 32'(bus.out_valid), 0);
        check("t1_in_ready_back", 32'(bus.in_ready), 1);
        check("t1_diff_kept", 32'(bus.diff), 7);
        bus.out_ready = 1'b0;

        // Borrow, wrap and extreme operand pairs.
        for (int i = 0; i < 5; i++) begin
            send(tbl_a[i], tbl_b[i], tbl_d[i], tbl_c[i]);
            receive(0, 1'b0);
        end

        // Backpressure in DONE plus ignored in_valid pulses in SHIFT and DONE.
        send(8'd77, 8'd12, 8'd65, 1'b0);
        bus.a        = 8'd99;
        bus.b        = 8'd1;
        bus.in_valid = 1'b1;
        @(negedge clk);
        bus.in_valid = 1'b0;
        for (int i = 0; i < 4 * WIDTH && !bus.out_valid; i++) @(negedge clk);
        check("bp_out_valid_seen", 32'(bus.out_valid), 1);
        d0           = bus.diff;
        c0           = bus.borrow_out;
        bus.a        = 8'd99;
        bus.b        = 8'd0;
        bus.in_valid = 1'b1;
        for (int i = 0; i < 5; i++) begin
            check("bp_out_valid", 32'(bus.out_valid), 1);
            check("bp_in_ready", 32'(bus.in_ready), 0);
            check("bp_diff_stable", 32'(bus.diff), 32'(d0));
            check("bp_borrow_stable", 32'(bus.borrow_out), 32'(c0));
            @(negedge clk);
        end
        bus.in_valid = 1'b0;
        receive(0, 1'b0);
        @(negedge clk);
        check("bp_not_accepted", 32'(bus.busy), 0);

        // Reset while cnt=4 discards the operation without an out_valid pulse.
        send(8'd100, 8'd1, 8'd99, 1'b0);
        repeat (4) @(negedge clk);
        rst_n = 1'b0;
        @(negedge clk);
        rst_n = 1'b1;
        sb_q.delete();
        check("mr_in_ready", 32'(bus.in_ready), 1);
        check("mr_out_valid", 32'(bus.out_valid), 0);
        check("mr_busy", 32'(bus.busy), 0);
        check("mr_diff", 32'(bus.diff), 0);
        seen = 1'b0;
        for (int i = 0; i < 2 * WIDTH; i++) begin
            seen = seen | bus.out_valid;
            @(negedge clk);
        end
        check("mr_no_spurious", 32'(seen), 0);
        send(8'd200, 8'd55, 8'd145, 1'b0);
        receive(0, 1'b0);

        // Back-to-back random operands with random consumer stalls.
        for (int i = 0; i < 1000; i++) begin
            ra = WIDTH'($urandom);
            rb = WIDTH'($urandom);
            send(ra, rb, WIDTH'(ra - rb), (ra < rb));
            receive($urandom_range(0, 3), 1'b1);
        end

        check("sb_drained", 32'(sb_q.size()), 0);
        $display("%0d/%0d checks passed", n_pass, n_checks);
        $finish;
    end
endmodule
